// File: rtl/pocket_cen_pkg.sv
// Shared types and the ratio-write validity rule for the fractional clock-enable generator.
package pocket_cen_pkg;

    localparam int unsigned CFG_W = 32;

    typedef struct packed {
        logic [CFG_W-1:0] num;
        logic [CFG_W-1:0] den;
    } ratio_t;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_st_t;

    // A write is accepted only for an existing channel with 0 < num <= den.
    function automatic logic cfg_valid(input logic [CFG_W-1:0] ch,
                                       input logic [CFG_W-1:0] nch,
                                       input ratio_t           r);
        return (ch < nch) && (r.num != '0) && (r.den != '0) && (r.num <= r.den);
    endfunction

endpackage

// File: rtl/pocket_frac_cen_ch.sv
// One fractional clock-enable channel: num/den accumulator with a registered cen pulse.
module pocket_frac_cen_ch #(
    parameter int unsigned W        = 16,
    parameter int unsigned NUM_INIT = 4,
    parameter int unsigned DEN_INIT = 11
) (
    input  logic         refclk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] num_i,
    input  logic [W-1:0] den_i,
    output logic         cen_o
);

    logic [W-1:0] num_q;
    logic [W-1:0] den_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic         cen_q;
    logic         cen_d;
    logic [W:0]   sum;

    // acc < den and num <= den keep sum within W+1 bits.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, num_q};
        acc_d = sum[W-1:0];
        cen_d = 1'b0;
        if (sum >= {1'b0, den_q}) begin
            acc_d = W'(sum - {1'b0, den_q});
            cen_d = 1'b1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            num_q <= W'(NUM_INIT);
            den_q <= W'(DEN_INIT);
            acc_q <= '0;
            cen_q <= 1'b0;
        end else if (load_i) begin
            num_q <= num_i;
            den_q <= den_i;
            acc_q <= '0;
            cen_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cen_q <= cen_d;
        end
    end

    assign cen_o = cen_q;

endmodule

// File: rtl/pocket_frac_cen.sv
// Multi-channel fractional clock-enable generator with run-time ratio writes and lock indication.
module pocket_frac_cen
    import pocket_cen_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter int unsigned W           = 16,
    parameter int unsigned NUM_INIT    = 4,
    parameter int unsigned DEN_INIT    = 11,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            refclk,
    input  logic            rst,
    input  logic            cfg_wr,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [W-1:0]    cfg_num,
    input  logic [W-1:0]    cfg_den,
    output logic            cfg_ack,
    output logic            cfg_err,
    output logic [NCH-1:0]  cen,
    output logic            locked
);

    localparam int unsigned LC_W = $clog2(LOCK_CYCLES + 1);

    if (NCH < 1 || NCH > 8 || W < 2 || W > CFG_W || LOCK_CYCLES < 1) begin : g_bad_param
        $error("pocket_frac_cen: NCH, W or LOCK_CYCLES out of range");
    end
    if (NUM_INIT == 0 || DEN_INIT == 0 || NUM_INIT > DEN_INIT ||
        (W < 32 && 64'(DEN_INIT) >= (64'd1 << W))) begin : g_bad_init
        $error("pocket_frac_cen: NUM_INIT/DEN_INIT out of range");
    end

    ratio_t          wr_ratio;
    logic            wr_valid_c;
    logic [NCH-1:0]  load_c;
    logic [LC_W-1:0] lcnt_q;
    logic [LC_W-1:0] lcnt_d;
    lock_st_t        state_q;
    logic            locked_q;
    logic            ack_q;
    logic            err_q;

    always_comb begin
        wr_ratio.num = CFG_W'(cfg_num);
        wr_ratio.den = CFG_W'(cfg_den);
        wr_valid_c   = cfg_wr && cfg_valid(CFG_W'(cfg_ch), CFG_W'(NCH), wr_ratio);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign load_c[i] = wr_valid_c && (cfg_ch == CH_W'(i));

        pocket_frac_cen_ch #(
            .W        (W),
            .NUM_INIT (NUM_INIT),
            .DEN_INIT (DEN_INIT)
        ) u_ch (
            .refclk (refclk),
            .rst    (rst),
            .load_i (load_c[i]),
            .num_i  (cfg_num),
            .den_i  (cfg_den),
            .cen_o  (cen[i])
        );
    end

    // Saturating count of edges since reset or the last accepted write.
    always_comb begin
        lcnt_d = lcnt_q;
        if (wr_valid_c) begin
            lcnt_d = '0;
        end else if (lcnt_q < LC_W'(LOCK_CYCLES)) begin
            lcnt_d = lcnt_q + LC_W'(1);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
            lcnt_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            ack_q  <= wr_valid_c;
            err_q  <= cfg_wr && !wr_valid_c;
            case (state_q)
                ST_UNLOCKED: begin
                    if (lcnt_d == LC_W'(LOCK_CYCLES)) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (wr_valid_c) begin
                        state_q  <= ST_UNLOCKED;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_UNLOCKED;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_pocket_frac_cen.sv
// Bench for pocket_frac_cen: closed-form rate model checked every cycle plus literal pins.
module tb_pocket_frac_cen;

    localparam int unsigned NCH  = 3;
    localparam int unsigned LOCK = 16;

    logic           refclk = 1'b0;
    logic           rst;
    logic           cfg_wr;
    logic [1:0]     cfg_ch;
    logic [15:0]    cfg_num;
    logic [15:0]    cfg_den;
    logic           cfg_ack;
    logic           cfg_err;
    logic [NCH-1:0] cen;
    logic           locked;

    logic           c8_wr;
    logic [0:0]     c8_ch;
    logic [7:0]     c8_num;
    logic [7:0]     c8_den;
    logic           c8_ack;
    logic           c8_err;
    logic [0:0]     c8_cen;
    logic           c8_locked;

    pocket_frac_cen #(
        .NCH(NCH), .W(16), .NUM_INIT(4), .DEN_INIT(11), .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk  (refclk),
        .rst     (rst),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_num (cfg_num),
        .cfg_den (cfg_den),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err),
        .cen     (cen),
        .locked  (locked)
    );

    pocket_frac_cen #(
        .NCH(1), .W(8), .NUM_INIT(4), .DEN_INIT(11), .LOCK_CYCLES(LOCK)
    ) dut8 (
        .refclk  (refclk),
        .rst     (rst),
        .cfg_wr  (c8_wr),
        .cfg_ch  (c8_ch),
        .cfg_num (c8_num),
        .cfg_den (c8_den),
        .cfg_ack (c8_ack),
        .cfg_err (c8_err),
        .cen     (c8_cen),
        .locked  (c8_locked)
    );

    always #5 refclk = ~refclk;

    int unsigned n_checks;
    int unsigned n_err;

    longint m_num [NCH];
    longint m_den [NCH];
    longint m_n   [NCH];
    int     m_e;
    logic [NCH-1:0] e_cen;
    logic   e_ack;
    logic   e_err;
    logic   e_lock;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulses emitted in the first n edges after acc is cleared: floor(n*num/den).
    function automatic longint pulses(input longint n, input longint num, input longint den);
        return (n * num) / den;
    endfunction

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic predict();
        logic valid;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_num[i] = 4; m_den[i] = 11; m_n[i] = 0;
            end
            m_e = 0; e_cen = '0; e_ack = 0; e_err = 0; e_lock = 0;
        end else begin
            valid = cfg_wr && (int'(cfg_ch) < NCH) && (cfg_num != 0) &&
                    (cfg_den != 0) && (cfg_num <= cfg_den);
            e_ack = valid;
            e_err = cfg_wr && !valid;
            for (int i = 0; i < NCH; i++) begin
                if (valid && int'(cfg_ch) == i) begin
                    m_num[i] = longint'(cfg_num);
                    m_den[i] = longint'(cfg_den);
                    m_n[i]   = 0;
                    e_cen[i] = 1'b0;
                end else begin
                    m_n[i]   = m_n[i] + 1;
                    e_cen[i] = pulses(m_n[i], m_num[i], m_den[i]) !=
                               pulses(m_n[i] - 1, m_num[i], m_den[i]);
                end
            end
            if (valid) m_e = 0;
            else if (m_e < LOCK) m_e = m_e + 1;
            e_lock = (m_e >= LOCK);
        end
    endtask

    task automatic step();
        predict();
        @(posedge refclk);
        #1;
        check("cen", longint'(cen), longint'(e_cen));
        check("cfg_ack", longint'(cfg_ack), longint'(e_ack));
        check("cfg_err", longint'(cfg_err), longint'(e_err));
        check("locked", longint'(locked), longint'(e_lock));
    endtask

    task automatic wr(input int ch, input int num, input int den);
        cfg_wr  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_num = 16'(num);
        cfg_den = 16'(den);
        step();
        cfg_wr  = 1'b0;
    endtask

    initial begin
        int cnt [NCH];
        int first;
        int lk;

        n_checks = 0; n_err = 0;
        rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0;
        c8_wr = 1'b0; c8_ch = '0; c8_num = '0; c8_den = '0;

        repeat (2) step();
        check("reset_cen", longint'(cen), 0);
        check("reset_locked", longint'(locked), 0);
        rst = 1'b0;

        // Defaults: 1100 cycles at 4/11.
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        first = 0; lk = 0;
        for (int k = 1; k <= 1100; k++) begin
            step();
            for (int i = 0; i < NCH; i++) cnt[i] += int'(cen[i]);
            if (first == 0 && cen[0]) first = k;
            if (lk == 0 && locked) lk = k;
        end
        for (int i = 0; i < NCH; i++) check("default_pulses", cnt[i], 400);
        check("first_pulse_edge", first, 3);
        check("lock_edge", lk, 16);

        // ch1 -> 1/1: ack, lock drop and re-lock 16 edges later.
        wr(1, 1, 1);
        check("ack_ch1", longint'(cfg_ack), 1);
        check("unlock_on_wr", longint'(locked), 0);
        lk = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (lk == 0 && locked) lk = k;
            check("cen1_full_rate", longint'(cen[1]), 1);
        end
        check("relock_edge", lk, 16);

        // Invalid writes: error pulse, lock held.
        wr(0, 5, 3);
        check("err_num_gt_den", longint'(cfg_err), 1);
        check("lock_kept_a", longint'(locked), 1);
        wr(0, 0, 5);
        check("err_num_zero", longint'(cfg_err), 1);
        check("lock_kept_b", longint'(locked), 1);
        wr(3, 1, 2);
        check("err_bad_ch", longint'(cfg_err), 1);
        check("lock_kept_c", longint'(locked), 1);
        repeat (5) step();

        // Back-to-back ch0 writes 1/2 then 3/7.
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_num = 16'd1; cfg_den = 16'd2;
        step();
        check("ack_b2b_1", longint'(cfg_ack), 1);
        cfg_num = 16'd3; cfg_den = 16'd7;
        step();
        check("ack_b2b_2", longint'(cfg_ack), 1);
        cfg_wr = 1'b0;
        cnt[0] = 0;
        for (int k = 1; k <= 70; k++) begin
            step();
            cnt[0] += int'(cen[0]);
        end
        check("rate_3_of_7", cnt[0], 30);

        // Mid-stream reset right after an accepted write.
        wr(2, 2, 5);
        check("ack_before_rst", longint'(cfg_ack), 1);
        rst = 1'b1;
        #1;
        check("rst_async_cen", longint'(cen), 0);
        check("rst_async_locked", longint'(locked), 0);
        check("rst_async_ack", longint'(cfg_ack), 0);
        predict();
        step();
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        for (int k = 1; k <= 33; k++) begin
            step();
            for (int i = 0; i < NCH; i++) cnt[i] += int'(cen[i]);
        end
        for (int i = 0; i < NCH; i++) check("post_rst_4_of_11", cnt[i], 12);

        // W=8 build at 255/255.
        c8_wr = 1'b1; c8_ch = 1'b0; c8_num = 8'd255; c8_den = 8'd255;
        step();
        check("w8_ack", longint'(c8_ack), 1);
        check("w8_cen_on_load", longint'(c8_cen), 0);
        c8_wr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("w8_cen_const", longint'(c8_cen), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
